// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: single-outstanding instruction fetch FSM with redirect squash; MISALIGN_TRAP_EN enables the misaligned-redirect trap
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_out,
  input  logic [31:0] next_pc_in,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        misalign_trap,
  output logic [31:0] trap_addr
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, TRAP} state_t;
  state_t state, state_n;
  logic squash, squash_n, capture, active, redir, bad;
  logic [31:0] pc_n, target;
  assign active = state == REQ || state == WAIT || state == HOLD;
`ifdef MISALIGN_TRAP_EN
  assign bad = active && branch_taken && branch_target[1:0] != 2'b00;
  assign target = branch_target;
`else
  assign bad = 1'b0;
  assign target = branch_target & 32'hFFFF_FFFC;
`endif
  assign redir = active && branch_taken && !bad;
  assign imem_req_valid = state == REQ;
  assign imem_req_addr = pc_out;
  assign instr_valid = state == HOLD;
  assign pc_n = redir ? target : (state == HOLD && instr_ready && !branch_taken) ? next_pc_in : pc_out;
  always_comb begin
    state_n = state;
    squash_n = squash;
    capture = 1'b0;
    case (state)
      IDLE: state_n = REQ;
      REQ: begin
        state_n = imem_req_ready ? WAIT : REQ;
        squash_n = redir && imem_req_ready;
      end
      WAIT: begin
        state_n = !imem_rsp_valid ? WAIT : (branch_taken || squash) ? REQ : HOLD;
        squash_n = !imem_rsp_valid && (squash || branch_taken);
        capture = imem_rsp_valid && !branch_taken && !squash;
      end
      HOLD: state_n = (branch_taken || instr_ready) ? REQ : HOLD;
      default: state_n = state;
    endcase
    if (bad) state_n = TRAP;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      pc_out <= RESET_PC;
      squash <= 1'b0;
      instr_out <= '0;
      instr_pc <= '0;
    end else begin
      state <= state_n;
      pc_out <= pc_n;
      squash <= squash_n;
      if (capture) begin
        instr_out <= imem_rsp_data;
        instr_pc <= pc_out;
      end
    end
`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk)
    if (rst) begin
      misalign_trap <= 1'b0;
      trap_addr <= '0;
    end else begin
      misalign_trap <= bad;
      if (bad) trap_addr <= branch_target;
    end
`else
  assign misalign_trap = 1'b0;
  assign trap_addr = '0;
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed and randomized checks of pc_fetch_unit against a program-order fetch model
module tb_pc_fetch_unit;
  logic clk = 1'b0, rst;
  logic [31:0] pc_out, next_pc_in, branch_target, imem_req_addr, imem_rsp_data, instr_out, instr_pc, trap_addr;
  logic branch_taken, imem_req_valid, imem_req_ready, imem_rsp_valid, instr_valid, instr_ready, misalign_trap;
  int errors = 0, checks = 0;
  logic pend;
  logic [31:0] pend_addr;
  int pend_cnt;
  pc_fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .pc_out(pc_out), .next_pc_in(next_pc_in),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out), .instr_pc(instr_pc),
    .misalign_trap(misalign_trap), .trap_addr(trap_addr)
  );
  assign next_pc_in = pc_out + 32'd4;
  always #5 clk = ~clk;
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic drive_mem(input int lat);
    imem_rsp_valid = 1'b0;
    if (pend) begin
      if (pend_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data = word_of(pend_addr);
        pend = 1'b0;
      end else pend_cnt--;
    end
    if (imem_req_valid && imem_req_ready) begin
      pend = 1'b1;
      pend_addr = imem_req_addr;
      pend_cnt = lat;
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    branch_taken = 1'b0;
    branch_target = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    instr_ready = 1'b0;
    pend = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask
  task automatic fetch_one(output logic ok, output logic [31:0] ipc, output logic [31:0] iw, output int cyc);
    ok = 1'b0;
    ipc = '0;
    iw = '0;
    cyc = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      imem_req_ready = 1'b1;
      instr_ready = 1'b1;
      branch_taken = 1'b0;
      drive_mem(0);
      if (instr_valid) begin
        ok = 1'b1;
        ipc = instr_pc;
        iw = instr_out;
      end
      tick();
      cyc++;
    end
  endtask
  task automatic reach_hold(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      imem_req_ready = 1'b1;
      instr_ready = 1'b0;
      branch_taken = 1'b0;
      drive_mem(0);
      if (instr_valid) ok = 1'b1;
      else tick();
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h0000_0200;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h1234_5678;
    instr_ready = 1'b1;
    pend = 1'b0;
    tick();
    tick();
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc_out, 32'h0); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid); end
    checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL reset_instr_out: got %h expected 0", instr_out); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h expected 0", instr_pc); end
    checks++; if (misalign_trap !== 1'b0) begin errors++; $display("FAIL reset_trap: got %b expected 0", misalign_trap); end
    checks++; if (trap_addr !== 32'h0) begin errors++; $display("FAIL reset_trap_addr: got %h expected 0", trap_addr); end
    rst = 1'b0;
    branch_taken = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    tick();
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid: got %b expected 1", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL first_req_addr: got %h expected 0", imem_req_addr); end
  endtask
  task automatic test_fetch_seq();
    logic ok;
    logic [31:0] ipc, iw;
    int cyc;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      fetch_one(ok, ipc, iw, cyc);
      checks++; if (!ok) begin errors++; $display("FAIL seq_timeout[%0d]: got none expected instruction", i); end
      checks++; if (ipc !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, ipc, 32'(4 * i)); end
      checks++; if (iw !== word_of(32'(4 * i))) begin errors++; $display("FAIL seq_word[%0d]: got %h expected %h", i, iw, word_of(32'(4 * i))); end
      checks++; if (cyc != 3) begin errors++; $display("FAIL seq_cycles[%0d]: got %0d expected 3", i, cyc); end
    end
  endtask
  task automatic test_hold_stall();
    logic ok;
    logic [31:0] ipc, iw;
    int cyc;
    do_reset();
    reach_hold(ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_reach: got no instr_valid expected 1"); end
    for (int i = 0; i < 5; i++) begin
      instr_ready = 1'b0;
      imem_req_ready = 1'b1;
      drive_mem(0);
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b expected 1", i, instr_valid); end
      checks++; if (instr_out !== word_of(32'h0)) begin errors++; $display("FAIL hold_word[%0d]: got %h expected %h", i, instr_out, word_of(32'h0)); end
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL hold_no_req[%0d]: got %b expected 0", i, imem_req_valid); end
      checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL hold_pc[%0d]: got %h expected 0", i, pc_out); end
      tick();
    end
    fetch_one(ok, ipc, iw, cyc);
    checks++; if (!ok || ipc !== 32'h0) begin errors++; $display("FAIL hold_release: got %h expected 0", ipc); end
    fetch_one(ok, ipc, iw, cyc);
    checks++; if (!ok || ipc !== 32'h4) begin errors++; $display("FAIL hold_next: got %h expected 4", ipc); end
  endtask
  task automatic test_redirect_wait();
    logic ok;
    logic [31:0] ipc, iw;
    int cyc;
    do_reset();
    imem_req_ready = 1'b1;
    instr_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    branch_taken = 1'b1;
    branch_target = 32'h0000_0100;
    tick();
    branch_taken = 1'b0;
    checks++; if (pc_out !== 32'h100) begin errors++; $display("FAIL redir_pc: got %h expected 100", pc_out); end
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    pend = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin errors++; $display("FAIL redir_req: got valid=%b addr=%h expected valid=1 addr=100", imem_req_valid, imem_req_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_drop: got %b expected 0", instr_valid); end
    fetch_one(ok, ipc, iw, cyc);
    checks++; if (!ok || ipc !== 32'h100 || iw !== word_of(32'h100)) begin errors++; $display("FAIL redir_fetch: got pc=%h word=%h expected pc=100 word=%h", ipc, iw, word_of(32'h100)); end
  endtask
  task automatic test_wrap();
    logic ok;
    logic [31:0] ipc, iw;
    int cyc;
    do_reset();
    imem_req_ready = 1'b0;
    branch_taken = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req: got valid=%b addr=%h expected valid=1 addr=fffffffc", imem_req_valid, imem_req_addr); end
    fetch_one(ok, ipc, iw, cyc);
    checks++; if (!ok || ipc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_last: got %h expected fffffffc", ipc); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got valid=%b addr=%h expected valid=1 addr=0", imem_req_valid, imem_req_addr); end
    fetch_one(ok, ipc, iw, cyc);
    checks++; if (!ok || ipc !== 32'h0) begin errors++; $display("FAIL wrap_first: got %h expected 0", ipc); end
  endtask
  task automatic test_misalign();
    logic ok;
    logic [31:0] ipc, iw;
    int cyc;
    do_reset();
    reach_hold(ok);
    checks++; if (!ok) begin errors++; $display("FAIL mis_reach: got no instr_valid expected 1"); end
    instr_ready = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h0000_0102;
    tick();
    branch_taken = 1'b0;
`ifdef MISALIGN_TRAP_EN
    checks++; if (misalign_trap !== 1'b1 || trap_addr !== 32'h102) begin errors++; $display("FAIL mis_trap: got trap=%b addr=%h expected trap=1 addr=102", misalign_trap, trap_addr); end
    for (int i = 0; i < 4; i++) begin
      imem_req_ready = 1'b1;
      instr_ready = 1'b1;
      tick();
      checks++; if (misalign_trap !== 1'b0 || imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL mis_hold[%0d]: got trap=%b req=%b iv=%b expected all 0", i, misalign_trap, imem_req_valid, instr_valid); end
    end
`else
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin errors++; $display("FAIL mis_addr: got valid=%b addr=%h expected valid=1 addr=100", imem_req_valid, imem_req_addr); end
    checks++; if (misalign_trap !== 1'b0 || trap_addr !== 32'h0) begin errors++; $display("FAIL mis_tied: got trap=%b addr=%h expected 0", misalign_trap, trap_addr); end
    fetch_one(ok, ipc, iw, cyc);
    checks++; if (!ok || ipc !== 32'h100) begin errors++; $display("FAIL mis_fetch: got %h expected 100", ipc); end
`endif
  endtask
  task automatic test_reset_mid();
    logic ok;
    logic [31:0] ipc, iw;
    int cyc;
    do_reset();
    branch_taken = 1'b1;
    branch_target = 32'h0000_0040;
    tick();
    branch_taken = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    rst = 1'b1;
    imem_req_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    pend = 1'b0;
    checks++; if (pc_out !== 32'h0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL mid_reset: got pc=%h req=%b expected pc=0 req=0", pc_out, imem_req_valid); end
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hBAD0_BAD0;
    tick();
    tick();
    imem_rsp_valid = 1'b0;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || instr_valid !== 1'b0) begin errors++; $display("FAIL mid_ignore: got req=%b addr=%h iv=%b expected req=1 addr=0 iv=0", imem_req_valid, imem_req_addr, instr_valid); end
    fetch_one(ok, ipc, iw, cyc);
    checks++; if (!ok || ipc !== 32'h0 || iw !== word_of(32'h0)) begin errors++; $display("FAIL mid_first: got pc=%h word=%h expected pc=0 word=%h", ipc, iw, word_of(32'h0)); end
  endtask
  task automatic test_random();
    logic [31:0] expect_pc, t;
    int consumed = 0;
    do_reset();
    expect_pc = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      imem_req_ready = $urandom_range(3) != 0;
      instr_ready = $urandom_range(3) != 0;
      branch_taken = $urandom_range(15) == 0;
      t = $urandom;
      if ($urandom_range(3) == 0) t = {20'hFFFFF, t[11:0]};
`ifdef MISALIGN_TRAP_EN
      t = t & 32'hFFFF_FFFC;
`endif
      branch_target = t;
      checks++; if (imem_req_valid && pend) begin errors++; $display("FAIL rnd_outstanding[%0d]: got second request expected none", n); end
      drive_mem($urandom_range(2));
      checks++; if (imem_req_addr !== pc_out) begin errors++; $display("FAIL rnd_addr[%0d]: got %h expected %h", n, imem_req_addr, pc_out); end
      checks++; if (imem_req_valid && instr_valid) begin errors++; $display("FAIL rnd_req_in_hold[%0d]: got req=1 expected 0", n); end
      if (branch_taken) expect_pc = t & 32'hFFFF_FFFC;
      else if (instr_valid && instr_ready) begin
        checks++; if (instr_pc !== expect_pc || instr_out !== word_of(expect_pc)) begin errors++; $display("FAIL rnd_instr[%0d]: got pc=%h word=%h expected pc=%h word=%h", n, instr_pc, instr_out, expect_pc, word_of(expect_pc)); end
        expect_pc += 32'd4;
        consumed++;
      end
      tick();
    end
    branch_taken = 1'b0;
    checks++; if (consumed < 50) begin errors++; $display("FAIL rnd_progress: got %0d expected at least 50", consumed); end
  endtask
  initial begin
    test_reset();
    test_fetch_seq();
    test_hold_stall();
    test_redirect_wait();
    test_wrap();
    test_reset_mid();
    test_random();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] SHALL be 0.
REQ-002 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 pc_out  output  32  current PC; drives the PC+4 adder input.
REQ-005 next_pc_in  input  32  PC+4 returned from the adder, combinational from pc_out.
REQ-006 branch_taken  input  1  one-cycle redirect strobe.
REQ-007 branch_target  input  32  redirect address, valid when branch_taken=1.
REQ-008 imem_req_valid  output  1  fetch request valid.
REQ-009 imem_req_ready  input  1  instruction memory accepts request.
REQ-010 imem_req_addr  output  32  fetch address; SHALL equal pc_out.
REQ-011 imem_rsp_valid  input  1  instruction word returned, one cycle.
REQ-012 imem_rsp_data  input  32  instruction word.
REQ-013 instr_valid  output  1  buffered instruction available to decode.
REQ-014 instr_ready  input  1  decode consumes instruction.
REQ-015 instr_out / instr_pc  output  32 each  buffered instruction and its PC.
REQ-016 misalign_trap / trap_addr  output  1 / 32  misaligned-redirect report (see Configuration).

Function
REQ-017 States: IDLE, REQ, WAIT, HOLD, TRAP; SHALL be one-hot or binary, implementer's choice.
REQ-018 IDLE -> REQ unconditionally on the first edge with rst=0.
REQ-019 REQ: imem_req_valid=1; imem_req_ready=1 -> WAIT; else stay; addr SHALL stay stable except on redirect.
REQ-020 WAIT: imem_rsp_valid=1 and squash=0 -> capture data into instr_out, instr_pc<=pc_out, -> HOLD.
REQ-021 WAIT: imem_rsp_valid=1 and squash=1 -> discard word, clear squash, -> REQ.
REQ-022 HOLD: instr_valid=1; instr_valid&instr_ready -> pc<=next_pc_in, -> REQ; instr_out stable until consumed.
REQ-023 Redirect (branch_taken=1, aligned target) SHALL load pc<=branch_target in any of REQ/WAIT/HOLD.
REQ-024 Redirect in REQ with imem_req_ready=1, or in WAIT without a same-cycle response -> set squash, -> WAIT.
REQ-025 Redirect in REQ with imem_req_ready=0 -> stay REQ with new address, no squash.
REQ-026 Redirect in WAIT with imem_rsp_valid=1 -> drop word, -> REQ.
REQ-027 Redirect in HOLD -> drop buffered instruction, no handshake credited, -> REQ; redirect outranks instr_ready.
REQ-028 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC advances to 32'h0000_0000 without special handling.
REQ-029 At most one request SHALL be outstanding; imem_req_valid SHALL be 0 in WAIT/HOLD/TRAP/IDLE.
REQ-030 Minimum throughput: one instruction per 3 cycles with zero-wait memory and instr_ready=1.

Reset
REQ-031 rst=1 SHALL force state=IDLE, pc_out=RESET_PC, squash=0, instr_out=0, instr_pc=0, imem_req_valid=0, instr_valid=0, misalign_trap=0, trap_addr=0.
REQ-032 rst asserted mid-transaction SHALL abandon it; a response arriving after reset release while in IDLE/REQ SHALL be ignored.

Configuration
REQ-033 Macro MISALIGN_TRAP_EN defined: redirect with branch_target[1:0]!=0 SHALL not load PC, SHALL pulse misalign_trap for one cycle with trap_addr=branch_target, and -> TRAP; TRAP holds all handshakes low until rst.
REQ-034 Macro MISALIGN_TRAP_EN undefined: branch_target[1:0] SHALL be forced to 2'b00 on load; misalign_trap and trap_addr tied 0; TRAP unreachable.

Verification
REQ-035 Reset release, RESET_PC=0, memory ready, rsp 1 cycle later, instr_ready=1 -> fetch addrs 0x0,0x4,0x8 with instr_pc matching.
REQ-036 instr_ready=0 for 5 cycles in HOLD -> instr_valid held, instr_out stable, no new request, pc_out unchanged.
REQ-037 branch_taken target 0x100 in WAIT, rsp 0xDEADBEEF arrives next cycle -> word dropped, next request addr 0x100.
REQ-038 pc=0xFFFF_FFFC consumed -> next request addr 0x0000_0000.
REQ-039 MISALIGN_TRAP_EN defined, redirect to 0x102 -> misalign_trap=1 one cycle, trap_addr=0x102, no further requests; undefined -> next request addr 0x100.
REQ-040 rst asserted in WAIT, late rsp arrives after release -> ignored, first instr_pc=RESET_PC.
